bnn_feat_loader: RTL and testbench

- Upstream/downstream sequencer for seq_bnn. It accepts a test sample as a serial stream of FEAT_BITS-wide features over a valid/ready handshake.
- It packs the features into the flat vector that seq_bnn consumes, pulses the core's reset to start an inference, and waits a fixed compute window.
- It then captures the core's prediction and offers it downstream on a valid/ready handshake.
- One instance sits beside each generated *_bs product wrapper.

---
 rtl/bnn_pkg.sv | 17 +
 rtl/bnn_feat_packer.sv | 32 +++
 rtl/bnn_feat_loader.sv | 147 ++++++++++++++
 tb/tb_bnn_feat_loader.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/bnn_pkg.sv
// Shared types and constants for the seq_bnn feature loader.
package bnn_pkg;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    KICK = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  localparam int FEAT_BITS = 4;

  function automatic int pred_w(input int class_cnt);
    return $clog2(class_cnt);
  endfunction

endpackage

// File: rtl/bnn_feat_packer.sv
// Feature slot register file exposing the packed vector for seq_bnn.
module bnn_feat_packer #(
  parameter int FEAT_CNT  = 11,
  parameter int FEAT_BITS = 4,
  parameter int IW        = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_we,
  input  logic [IW-1:0]                 i_idx,
  input  logic [FEAT_BITS-1:0]          i_data,
  output logic [FEAT_CNT*FEAT_BITS-1:0] o_features
);

  logic [FEAT_BITS-1:0] r_slot [FEAT_CNT];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FEAT_CNT; i++)
        r_slot[i] <= '0;
    end else if (i_we) begin
      for (int i = 0; i < FEAT_CNT; i++)
        if (i_idx == IW'(i))
          r_slot[i] <= i_data;
    end
  end

  for (genvar g = 0; g < FEAT_CNT; g++) begin : g_slot
    assign o_features[g*FEAT_BITS +: FEAT_BITS] = r_slot[g];
  end

endmodule

// File: rtl/bnn_feat_loader.sv
// Streams a sample into seq_bnn, times the inference and hands off the class.
module bnn_feat_loader #(
  parameter int FEAT_CNT       = 11,
  parameter int FEAT_BITS      = bnn_pkg::FEAT_BITS,
  parameter int CLASS_CNT      = 7,
  parameter int COMPUTE_CYCLES = 49,
  localparam int PW            = bnn_pkg::pred_w(CLASS_CNT)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [FEAT_BITS-1:0]          in_data,
  input  logic                          in_last,
  output logic [FEAT_CNT*FEAT_BITS-1:0] bnn_features,
  output logic                          bnn_rst,
  input  logic [PW-1:0]                 bnn_prediction,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [PW-1:0]                 out_class,
  output logic                          frame_err
);

  import bnn_pkg::*;

  localparam int IW = (FEAT_CNT > 1) ? $clog2(FEAT_CNT) : 1;
  localparam int CW = $clog2(COMPUTE_CYCLES + 1);
  localparam logic [IW-1:0] LAST_IDX = IW'(FEAT_CNT - 1);
  localparam logic [CW-1:0] CNT_END  = CW'(COMPUTE_CYCLES - 1);

  state_t        r_state, w_state;
  logic [IW-1:0] r_idx, w_idx;
  logic [CW-1:0] r_cnt, w_cnt;
  logic [PW-1:0] r_out_class, w_out_class;
  logic          r_drop, w_drop;
  logic          r_bnn_rst, w_bnn_rst;
  logic          r_out_valid, w_out_valid;
  logic          r_frame_err, w_frame_err;
  logic          r_run;
  logic          w_acc;
  logic          w_we;

  // r_run keeps in_ready low until the first edge after reset release
  assign in_ready  = r_run & (r_state == LOAD);
  assign w_acc     = in_valid & in_ready;
  assign bnn_rst   = r_bnn_rst;
  assign out_valid = r_out_valid;
  assign out_class = r_out_class;
  assign frame_err = r_frame_err;

  always_comb begin
    w_state     = r_state;
    w_idx       = r_idx;
    w_cnt       = r_cnt;
    w_drop      = r_drop;
    w_bnn_rst   = r_bnn_rst;
    w_out_valid = r_out_valid;
    w_out_class = r_out_class;
    w_frame_err = r_frame_err;
    w_we        = 1'b0;
    unique case (r_state)
      LOAD: begin
        w_bnn_rst = 1'b1;
        if (w_acc && r_drop) begin
          if (in_last)
            w_drop = 1'b0;
        end else if (w_acc) begin
          w_we = 1'b1;
          if (r_idx == LAST_IDX) begin
            w_idx = '0;
            if (in_last) begin
              w_state = KICK;
            end else begin
              w_frame_err = 1'b1;
              w_drop      = 1'b1;
            end
          end else if (in_last) begin
            w_idx       = '0;
            w_frame_err = 1'b1;
          end else begin
            w_idx = r_idx + 1'b1;
          end
        end
      end
      KICK: begin
        w_state   = WAIT;
        w_cnt     = '0;
        w_bnn_rst = 1'b0;
      end
      WAIT: begin
        if (r_cnt == CNT_END) begin
          w_out_class = bnn_prediction;
          w_out_valid = 1'b1;
          w_state     = HOLD;
        end else begin
          w_cnt = r_cnt + 1'b1;
        end
      end
      HOLD: begin
        if (out_ready) begin
          w_out_valid = 1'b0;
          w_bnn_rst   = 1'b1;
          w_state     = LOAD;
        end
      end
      default: w_state = LOAD;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= LOAD;
      r_idx       <= '0;
      r_cnt       <= '0;
      r_drop      <= 1'b0;
      r_bnn_rst   <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_class <= '0;
      r_frame_err <= 1'b0;
      r_run       <= 1'b0;
    end else begin
      r_state     <= w_state;
      r_idx       <= w_idx;
      r_cnt       <= w_cnt;
      r_drop      <= w_drop;
      r_bnn_rst   <= w_bnn_rst;
      r_out_valid <= w_out_valid;
      r_out_class <= w_out_class;
      r_frame_err <= w_frame_err;
      r_run       <= 1'b1;
    end
  end

  bnn_feat_packer #(
    .FEAT_CNT (FEAT_CNT),
    .FEAT_BITS(FEAT_BITS),
    .IW       (IW)
  ) u_packer (
    .clk       (clk),
    .rst       (rst),
    .i_we      (w_we),
    .i_idx     (r_idx),
    .i_data    (in_data),
    .o_features(bnn_features)
  );

endmodule

// File: tb/tb_bnn_feat_loader.sv
// Self-checking bench for bnn_feat_loader with a counting seq_bnn stub.
module tb_bnn_feat_loader;

  localparam int C = 49;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_data;
  logic        in_last;
  logic [43:0] bnn_features;
  logic        bnn_rst;
  logic [2:0]  bnn_prediction;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_class;
  logic        frame_err;

  int   checks;
  int   errors;
  bit   cmode;
  bit   model_err;
  int   stub_cnt;
  int   fsum;
  logic [3:0] cur_f [16];

  typedef struct {
    string tag;
    int    len;
    int    gap;
    int    bp;
    bit    cm;
  } vec_t;

  vec_t tbl [7];

  bnn_feat_loader dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_data       (in_data),
    .in_last       (in_last),
    .bnn_features  (bnn_features),
    .bnn_rst       (bnn_rst),
    .bnn_prediction(bnn_prediction),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_class     (out_class),
    .frame_err     (frame_err)
  );

  always #5 clk = ~clk;

  // stub core: counts cycles out of reset, prediction depends on its inputs
  always_ff @(posedge clk) begin
    if (bnn_rst) stub_cnt <= 0;
    else         stub_cnt <= stub_cnt + 1;
  end

  always_comb begin
    fsum = 0;
    for (int i = 0; i < 11; i++)
      fsum += int'(bnn_features[i*4 +: 4]);
    bnn_prediction = cmode ? 3'd5 : 3'(fsum + stub_cnt);
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic send_beat(input logic [3:0] d, input bit last,
                           output int st);
    st = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    while (in_ready !== 1'b1 && st < 300) begin
      @(negedge clk);
      st++;
    end
    if (st >= 300) chk("beat_timeout", 64'(st), 64'd0);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_data  = 4'($urandom);
  endtask

  task automatic do_frame(input string tag, input int len, input int gap,
                          input int bp, input bit cm);
    int          st, lat, low, s, g;
    bit          ok;
    logic [43:0] exp_pk;
    logic [2:0]  exp_cls;
    cmode     = cm;
    out_ready = (bp == 0);
    for (int b = 0; b < len; b++) begin
      send_beat(cur_f[b], b == len - 1, st);
      if (b >= 11) chk({tag, "_drop_stall"}, 64'(st), 64'd0);
      if (b != len - 1) begin
        g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
        repeat (g) @(negedge clk);
      end
    end
    if (len != 11) begin
      model_err = 1'b1;
      ok = 1'b1;
      repeat (3) begin
        if (bnn_rst !== 1'b1 || in_ready !== 1'b1) ok = 1'b0;
        @(negedge clk);
      end
      chk({tag, "_err"}, 64'(frame_err), 64'(model_err));
      chk({tag, "_idle"}, 64'(ok), 64'd1);
      return;
    end
    exp_pk = '0;
    s = 0;
    for (int i = 0; i < 11; i++) begin
      exp_pk[i*4 +: 4] = cur_f[i];
      s += int'(cur_f[i]);
    end
    exp_cls = cm ? 3'd5 : 3'(s + C - 1);
    chk({tag, "_pack"}, 64'(bnn_features), 64'(exp_pk));
    chk({tag, "_kick_ready"}, 64'(in_ready), 64'd0);
    lat = 0;
    low = 0;
    while (out_valid !== 1'b1 && lat < 200) begin
      if (bnn_rst === 1'b0) low++;
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 64'(lat), 64'(C + 1));
    chk({tag, "_rst_low"}, 64'(low), 64'(C));
    chk({tag, "_class"}, 64'(out_class), 64'(exp_cls));
    chk({tag, "_err"}, 64'(frame_err), 64'(model_err));
    ok = 1'b1;
    for (int k = 0; k < bp; k++) begin
      @(negedge clk);
      if (out_valid !== 1'b1 || out_class !== exp_cls ||
          in_ready !== 1'b0 || bnn_rst !== 1'b0) ok = 1'b0;
    end
    if (bp > 0) chk({tag, "_hold"}, 64'(ok), 64'd1);
    out_ready = 1'b1;
    @(negedge clk);
    chk({tag, "_next"}, 64'({out_valid, in_ready, bnn_rst}), 64'b011);
  endtask

  initial begin
    int st, p, len;
    clk       = 1'b0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    cmode     = 1'b1;
    model_err = 1'b0;
    checks    = 0;
    errors    = 0;

    tbl[0] = '{"nominal",      11, 0,  0, 1'b1};
    tbl[1] = '{"backpressure", 11, 0, 20, 1'b1};
    tbl[2] = '{"short",         5, 0,  0, 1'b1};
    tbl[3] = '{"after_short",  11, 0,  0, 1'b0};
    tbl[4] = '{"long",         13, 0,  0, 1'b0};
    tbl[5] = '{"after_long",   11, 0,  1, 1'b1};
    tbl[6] = '{"gapped",       11, 2,  0, 1'b1};

    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(in_ready), 64'd0);
    chk("rst_bnn_rst", 64'(bnn_rst), 64'd1);
    chk("rst_out", 64'({out_valid, out_class, frame_err}), 64'd0);
    chk("rst_feat", 64'(bnn_features), 64'd0);
    rst = 1'b0;
    #1;
    chk("ready_pre_edge", 64'(in_ready), 64'd0);
    @(negedge clk);
    chk("ready_post_edge", 64'(in_ready), 64'd1);

    for (int i = 0; i < 16; i++) cur_f[i] = 4'(i + 1);
    for (int v = 0; v < 7; v++) begin
      do_frame(tbl[v].tag, tbl[v].len, tbl[v].gap, tbl[v].bp, tbl[v].cm);
      if (v == 0) chk("nominal_const", 64'(bnn_features), 64'hBA987654321);
    end

    // asynchronous abort during the compute window
    for (int i = 0; i < 16; i++) cur_f[i] = 4'($urandom);
    cmode = 1'b0;
    for (int b = 0; b < 11; b++) send_beat(cur_f[b], b == 10, st);
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_rst", 64'({bnn_rst, in_ready, out_valid}), 64'b100);
    chk("abort_out", 64'({out_class, frame_err}), 64'd0);
    chk("abort_feat", 64'(bnn_features), 64'd0);
    model_err = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("abort_ready", 64'(in_ready), 64'd1);
    for (int i = 0; i < 16; i++) cur_f[i] = 4'($urandom);
    do_frame("after_abort", 11, 0, 0, 1'b0);

    for (int r = 0; r < 30; r++) begin
      p = int'($urandom_range(0, 9));
      if (p < 7)      len = 11;
      else if (p < 8) len = int'($urandom_range(1, 10));
      else            len = int'($urandom_range(12, 15));
      for (int i = 0; i < 16; i++) cur_f[i] = 4'($urandom);
      do_frame("rand", len, -1, int'($urandom_range(0, 3)), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
